// File: rtl/input_feeder_pkg.sv
// Shared types and saturation helpers for the input feeder and the neuron/delta datapaths.
// The lane width is a parameter everywhere, so the saturation test works on any width up to 31 bits.
package input_feeder_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } feederState_t;

    // Saturation codes for the default 5-bit lane: 0 1...1 and 1 0...0.
    localparam int SAT_WF = 5;
    localparam logic [SAT_WF-1:0] SAT_MAX = {1'b0, {(SAT_WF-1){1'b1}}};
    localparam logic [SAT_WF-1:0] SAT_MIN = {1'b1, {(SAT_WF-1){1'b0}}};

    // A lane is zero-extended into 'lane'; wf is its true width.
    function automatic logic laneSaturated(input logic [31:0] lane, input int wf);
        logic [31:0] mask;
        logic [31:0] maxV;
        logic [31:0] minV;
        mask = (32'd1 << wf) - 32'd1;
        maxV = (32'd1 << (wf - 1)) - 32'd1;
        minV = 32'd1 << (wf - 1);
        return ((lane & mask) == maxV) || ((lane & mask) == minV);
    endfunction

endpackage

// File: rtl/input_feeder_if.sv
// Sample, forward-state, update-state and returned-delta channels of the input feeder.
// master is the feeder's view; slave is the view of the sample source and hidden layer.
interface input_feeder_if #(
    parameter int NP = 8,
    parameter int WF = 5,
    parameter int CW = 16
);
    logic                mode;
    logic                sampleValid;
    logic                sampleReady;
    logic [NP*WF-1:0]    sampleData;
    logic                state0Valid;
    logic                state0Ready;
    logic [NP*WF-1:0]    state0Data;
    logic                state1Valid;
    logic                state1Ready;
    logic [NP*WF-1:0]    state1Data;
    logic                deltaValid;
    logic                deltaReady;
    logic [NP*WF-1:0]    deltaData;
    logic                done;
    logic [CW-1:0]       count;
    logic                deltaSat;

    modport master (
        input  mode, sampleValid, sampleData, state0Ready, state1Ready, deltaValid, deltaData,
        output sampleReady, state0Valid, state0Data, state1Valid, state1Data, deltaReady,
               done, count, deltaSat
    );

    modport slave (
        output mode, sampleValid, sampleData, state0Ready, state1Ready, deltaValid, deltaData,
        input  sampleReady, state0Valid, state0Data, state1Valid, state1Data, deltaReady,
               done, count, deltaSat
    );
endinterface

// File: rtl/input_feeder_lane_sat_detect.sv
// Flags when any of NP packed two's-complement lanes sits at its most-positive or most-negative code.
module lane_sat_detect
    import input_feeder_pkg::*;
#(
    parameter int NP = 8,
    parameter int WF = 5
) (
    input  logic [NP*WF-1:0] lanes,
    output logic             anySat
);

    logic [NP-1:0] laneHit;

    for (genvar i = 0; i < NP; i++) begin : gLane
        assign laneHit[i] = laneSaturated(32'(lanes[i*WF +: WF]), WF);
    end

    assign anySat = |laneHit;

endmodule

// File: rtl/input_feeder.sv
// Feeds one input sample at a time into the first hidden layer: State0 always, State1 and the
// Delta0 sink only in training. The next sample is taken only after every required handshake.
module input_feeder
    import input_feeder_pkg::*;
#(
    parameter int NP = 8,
    parameter int WF = 5,
    parameter int CW = 16
) (
    input  logic         clock,
    input  logic         reset,
    input_feeder_if.master bus
);

    feederState_t        state;
    logic                modeR;
    logic                s0Done;
    logic                s1Done;
    logic                dDone;
    logic [NP*WF-1:0]    sampleReg;
    logic                doneR;
    logic [CW-1:0]       countR;
    logic                satR;

    logic                deltaHit;
    logic                sampleHs;
    logic                s0Hs;
    logic                s1Hs;
    logic                dHs;
    logic                complete;

    lane_sat_detect #(.NP(NP), .WF(WF)) satDetect (
        .lanes  (bus.deltaData),
        .anySat (deltaHit)
    );

    // Ready is held low during reset so no sample slips in on the reset edge.
    assign bus.sampleReady = (state == IDLE) && !reset;
    assign bus.state0Valid = (state == BUSY) && !s0Done;
    assign bus.state1Valid = (state == BUSY) && modeR && !s1Done;
    assign bus.deltaReady  = (state == BUSY) && modeR && !dDone;
    assign bus.state0Data  = sampleReg;
    assign bus.state1Data  = sampleReg;
    assign bus.done        = doneR;
    assign bus.count       = countR;
    assign bus.deltaSat    = satR;

    assign sampleHs = bus.sampleReady && bus.sampleValid;
    assign s0Hs     = bus.state0Valid && bus.state0Ready;
    assign s1Hs     = bus.state1Valid && bus.state1Ready;
    assign dHs      = bus.deltaReady  && bus.deltaValid;

    // Handshakes landing this cycle count, so completion never costs an extra cycle.
    assign complete = (state == BUSY) && (s0Done || s0Hs) &&
                      (!modeR || ((s1Done || s1Hs) && (dDone || dHs)));

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            modeR     <= 1'b0;
            s0Done    <= 1'b0;
            s1Done    <= 1'b0;
            dDone     <= 1'b0;
            sampleReg <= '0;
            doneR     <= 1'b0;
            countR    <= '0;
            satR      <= 1'b0;
        end else begin
            doneR <= 1'b0;
            if (dHs && deltaHit) begin
                satR <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (sampleHs) begin
                        sampleReg <= bus.sampleData;
                        modeR     <= bus.mode;
                        s0Done    <= 1'b0;
                        s1Done    <= 1'b0;
                        dDone     <= 1'b0;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (s0Hs) s0Done <= 1'b1;
                    if (s1Hs) s1Done <= 1'b1;
                    if (dHs)  dDone  <= 1'b1;
                    if (complete) begin
                        state  <= IDLE;
                        doneR  <= 1'b1;
                        countR <= countR + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_input_feeder.sv
// Self-checking bench for input_feeder: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_input_feeder;
    import input_feeder_pkg::*;

    localparam int NP = 8;
    localparam int WF = 5;
    localparam int CW = 16;
    localparam int DW = NP * WF;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    input_feeder_if #(.NP(NP), .WF(WF), .CW(CW)) bus ();
    input_feeder #(.NP(NP), .WF(WF), .CW(CW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    // Narrow-counter copy so the wrap to zero is reachable in a short run.
    input_feeder_if #(.NP(NP), .WF(WF), .CW(4)) wbus ();
    input_feeder #(.NP(NP), .WF(WF), .CW(4)) wdut (
        .clock (clock),
        .reset (reset),
        .bus   (wbus.master)
    );

    int compared   = 0;
    int mismatched = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic sv, input logic md, input logic [DW-1:0] sd,
                                 input logic r0, input logic r1, input logic dv,
                                 input logic [DW-1:0] dd);
        bus.sampleValid = sv;
        bus.mode        = md;
        bus.sampleData  = sd;
        bus.state0Ready = r0;
        bus.state1Ready = r1;
        bus.deltaValid  = dv;
        bus.deltaData   = dd;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // The model holds the sample in flight and the set of handshakes it still owes.
    bit            mBusy;
    logic [DW-1:0] mData;
    bit            mMode;
    bit            owesS0, owesS1, owesD;
    logic [CW-1:0] mCount;
    bit            mSat;
    bit            mDone;

    function automatic bit modelSat(input logic [DW-1:0] d);
        logic signed [WF-1:0] lane;
        int v;
        for (int i = 0; i < NP; i++) begin
            lane = d[i*WF +: WF];
            v = lane;
            if (v == (2 ** (WF - 1)) - 1 || v == -(2 ** (WF - 1))) return 1'b1;
        end
        return 1'b0;
    endfunction

    initial begin
        mBusy = 0; mData = '0; mMode = 0; owesS0 = 0; owesS1 = 0; owesD = 0;
        mCount = '0; mSat = 0; mDone = 0;
    end

    // Compare all outputs against the model mid-cycle, then advance the model to the next edge.
    always @(negedge clock) begin
        bit eReady, eS0, eS1, eDr;
        eReady = !reset && !mBusy;
        eS0    = mBusy && owesS0;
        eS1    = mBusy && owesS1;
        eDr    = mBusy && owesD;
        checkOutput("model.sampleReady", bus.sampleReady, eReady);
        checkOutput("model.state0Valid", bus.state0Valid, eS0);
        checkOutput("model.state1Valid", bus.state1Valid, eS1);
        checkOutput("model.deltaReady",  bus.deltaReady,  eDr);
        checkOutput("model.state0Data",  bus.state0Data,  mData);
        checkOutput("model.state1Data",  bus.state1Data,  mData);
        checkOutput("model.done",        bus.done,        mDone);
        checkOutput("model.count",       bus.count,       mCount);
        checkOutput("model.deltaSat",    bus.deltaSat,    mSat);
        if (reset) begin
            mBusy = 0; mData = '0; mMode = 0; owesS0 = 0; owesS1 = 0; owesD = 0;
            mCount = '0; mSat = 0; mDone = 0;
        end else begin
            mDone = 0;
            if (!mBusy) begin
                if (bus.sampleValid) begin
                    mBusy  = 1;
                    mData  = bus.sampleData;
                    mMode  = bus.mode;
                    owesS0 = 1;
                    owesS1 = bus.mode;
                    owesD  = bus.mode;
                end
            end else begin
                if (eS0 && bus.state0Ready) owesS0 = 0;
                if (eS1 && bus.state1Ready) owesS1 = 0;
                if (eDr && bus.deltaValid) begin
                    owesD = 0;
                    if (modelSat(bus.deltaData)) mSat = 1;
                end
                if (!owesS0 && !owesS1 && !owesD) begin
                    mBusy  = 0;
                    mDone  = 1;
                    mCount = mCount + 1'b1;
                end
            end
        end
    end

    logic [DW-1:0] sample;
    logic [DW-1:0] quietDelta;
    logic [DW-1:0] satDelta;

    initial begin
        reset = 1'b1;
        applyStimulus(0, 0, '0, 0, 0, 0, '0);
        wbus.sampleValid = 0; wbus.mode = 0; wbus.sampleData = '0;
        wbus.state0Ready = 1; wbus.state1Ready = 1; wbus.deltaValid = 0; wbus.deltaData = '0;
        quietDelta = {NP{5'b00011}};
        satDelta   = '0;
        satDelta[3*WF +: WF] = SAT_MAX;

        repeat (3) tick();
        checkOutput("reset.sampleReadyLow", bus.sampleReady, 1'b0);
        reset = 1'b0;
        #1;
        checkOutput("reset.sampleReady", bus.sampleReady, 1'b1);
        checkOutput("reset.count", bus.count, 0);
        checkOutput("reset.valid0", bus.state0Valid, 1'b0);
        checkOutput("reset.sat", bus.deltaSat, 1'b0);

        // Inference: a Delta0 valid is present but must never be taken.
        sample = 40'h12345_6789A;
        applyStimulus(1, 0, sample, 1, 1, 1, satDelta);
        tick();
        bus.sampleValid = 0;
        checkOutput("inf.valid0", bus.state0Valid, 1'b1);
        checkOutput("inf.data0", bus.state0Data, 40'h12345_6789A);
        checkOutput("inf.valid1", bus.state1Valid, 1'b0);
        checkOutput("inf.deltaReady", bus.deltaReady, 1'b0);
        checkOutput("inf.doneEarly", bus.done, 1'b0);
        tick();
        checkOutput("inf.done", bus.done, 1'b1);
        checkOutput("inf.count", bus.count, 1);
        checkOutput("inf.readyBack", bus.sampleReady, 1'b1);
        checkOutput("inf.satUntouched", bus.deltaSat, 1'b0);
        tick();
        checkOutput("inf.donePulse", bus.done, 1'b0);

        // Training with a slow State1 consumer and a late Delta0 beat.
        sample = {$urandom, 8'($urandom)};
        applyStimulus(1, 1, sample, 1, 0, 0, quietDelta);
        tick();
        bus.sampleValid = 0;
        bus.mode = 0;
        checkOutput("trn.valid1", bus.state1Valid, 1'b1);
        tick();
        tick();
        bus.deltaValid = 1;
        checkOutput("trn.deltaReady", bus.deltaReady, 1'b1);
        for (int c = 0; c < 2; c++) begin
            tick();
            bus.deltaValid = 0;
            checkOutput("trn.valid1Held", bus.state1Valid, 1'b1);
            checkOutput("trn.data1Held", bus.state1Data, sample);
            checkOutput("trn.readyLow", bus.sampleReady, 1'b0);
            checkOutput("trn.deltaTaken", bus.deltaReady, 1'b0);
        end
        tick();
        bus.state1Ready = 1;
        checkOutput("trn.notDoneYet", bus.done, 1'b0);
        tick();
        checkOutput("trn.done", bus.done, 1'b1);
        checkOutput("trn.count", bus.count, 2);
        checkOutput("trn.readyBack", bus.sampleReady, 1'b1);
        tick();

        // Training with all three handshakes on the same edge.
        applyStimulus(1, 1, ~sample, 1, 1, 1, quietDelta);
        tick();
        bus.sampleValid = 0;
        checkOutput("sim.valid0", bus.state0Valid, 1'b1);
        checkOutput("sim.valid1", bus.state1Valid, 1'b1);
        checkOutput("sim.deltaReady", bus.deltaReady, 1'b1);
        tick();
        bus.deltaValid = 0;
        checkOutput("sim.done", bus.done, 1'b1);
        checkOutput("sim.count", bus.count, 3);
        tick();

        // Saturated lane 3 in a returned delta; the flag must survive later samples.
        applyStimulus(1, 1, sample, 1, 1, 1, satDelta);
        tick();
        bus.sampleValid = 0;
        tick();
        bus.deltaValid = 0;
        checkOutput("sat.set", bus.deltaSat, 1'b1);
        for (int s = 0; s < 2; s++) begin
            tick();
            applyStimulus(1, 0, sample, 1, 1, 0, quietDelta);
            tick();
            bus.sampleValid = 0;
            tick();
            checkOutput("sat.sticky", bus.deltaSat, 1'b1);
        end
        checkOutput("sat.count", bus.count, 6);
        tick();

        // Reset while State0 is still owed.
        applyStimulus(1, 0, sample, 0, 1, 0, quietDelta);
        tick();
        bus.sampleValid = 0;
        checkOutput("rst.valid0Owed", bus.state0Valid, 1'b1);
        reset = 1'b1;
        tick();
        checkOutput("rst.readyLow", bus.sampleReady, 1'b0);
        reset = 1'b0;
        #1;
        checkOutput("rst.valid0", bus.state0Valid, 1'b0);
        checkOutput("rst.ready", bus.sampleReady, 1'b1);
        checkOutput("rst.count", bus.count, 0);
        checkOutput("rst.sat", bus.deltaSat, 1'b0);
        checkOutput("rst.data", bus.state0Data, 0);
        applyStimulus(1, 0, sample, 1, 1, 0, quietDelta);
        tick();
        bus.sampleValid = 0;
        tick();
        checkOutput("rst.afterDone", bus.done, 1'b1);
        checkOutput("rst.afterCount", bus.count, 1);

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 4000; c++) begin
            logic [DW-1:0] rd;
            reset = ($urandom_range(0, 249) == 0);
            rd = {$urandom, 8'($urandom)};
            if ($urandom_range(0, 3) != 0) rd = rd & {NP{5'b00111}};
            applyStimulus($urandom_range(0, 2) != 0, 1'($urandom), {$urandom, 8'($urandom)},
                          $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                          $urandom_range(0, 1) != 0, rd);
            tick();
        end
        reset = 1'b0;
        applyStimulus(0, 0, '0, 0, 0, 0, '0);
        tick();

        // Counter wrap on the narrow copy: 15 samples reach the top, the 16th wraps to zero.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wbus.sampleValid = 1;
        repeat (30) tick();
        checkOutput("wrap.top", wbus.count, 4'hF);
        checkOutput("wrap.topDone", wbus.done, 1'b1);
        repeat (2) tick();
        checkOutput("wrap.zero", wbus.count, 4'h0);
        checkOutput("wrap.zeroDone", wbus.done, 1'b1);
        wbus.sampleValid = 0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
